// File: rtl/countdown_ctrl.sv
// Countdown-timer sequencer: turns start/stop/set pulses into load/clear/enable
// controls for a cascaded BCD down-counter chain, with a tick prescaler and expiry alarm.
module countdown_ctrl #(
  parameter int TICK_DIV     = 100,
  parameter int ALARM_CYCLES = 8
) (
  input  logic       clock_i,
  input  logic       clr_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       set_i,
  input  logic       all_zero_i,
  output logic       loadn_o,
  output logic       cnt_clrn_o,
  output logic       en_o,
  output logic       done_o,
  output logic       alarm_o,
  output logic [2:0] state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_INIT = AW'(ALARM_CYCLES);
  localparam logic [AW-1:0] ALARM_ONE  = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d, presc_wrap;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          loadn_q, loadn_d;
  logic          cnt_clrn_q, cnt_clrn_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;

  assign presc_wrap = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    alarm_cnt_d = alarm_cnt_q;
    cnt_clrn_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!stop_i) begin
          if (set_i) begin
            state_d = ST_LOAD;
          end else if (start_i && !all_zero_i) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
      end

      ST_LOAD: state_d = ST_IDLE;

      ST_RUN: begin
        // The prescaler advances on every RUN edge, including the pausing one,
        // so a resume continues exactly where the tick period left off.
        presc_d = presc_wrap;
        if (all_zero_i) begin
          state_d     = ST_DONE;
          alarm_cnt_d = ALARM_INIT;
        end else if (stop_i) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (stop_i) begin
          state_d    = ST_IDLE;
          cnt_clrn_d = 1'b0;
        end else if (set_i) begin
          state_d = ST_LOAD;
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (stop_i || (alarm_cnt_q <= ALARM_ONE)) begin
          state_d     = ST_IDLE;
          alarm_cnt_d = '0;
        end else begin
          alarm_cnt_d = alarm_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it;
    // leaving RUN for DONE therefore suppresses the tick that would wrap the chain.
    loadn_d = (state_d != ST_LOAD);
    en_d    = (state_d == ST_RUN) && (presc_d == PRESC_LAST);
    done_d  = (state_d == ST_DONE);
    alarm_d = (state_d == ST_DONE) && (alarm_cnt_d != '0);
  end

  always_ff @(posedge clock_i or posedge clr_i) begin
    if (clr_i) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      loadn_q     <= 1'b1;
      cnt_clrn_q  <= 1'b1;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      alarm_cnt_q <= alarm_cnt_d;
      loadn_q     <= loadn_d;
      cnt_clrn_q  <= cnt_clrn_d;
      en_q        <= en_d;
      done_q      <= done_d;
      alarm_q     <= alarm_d;
    end
  end

  assign loadn_o    = loadn_q;
  assign cnt_clrn_o = cnt_clrn_q;
  assign en_o       = en_q;
  assign done_o     = done_q;
  assign alarm_o    = alarm_q;
  assign state_o    = state_q;

endmodule
